// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch entries with push/pop/clear; a push is accepted on a
// full FIFO only when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  fetch_entry_t            i_data,
    input  logic                    i_pop,
    output fetch_entry_t            o_head,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;

    logic w_push;
    logic w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rd];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage carries no reset; the head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns PCF, issues imem requests, buffers responses in order for decode.
// Optional macro FETCH_BYPASS_EN: an arriving response on an empty queue drives decode directly.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ImemReqValid,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemReqReady,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    input  logic        StallD,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValidD,
    output logic [31:0] InstrD,
    output logic [6:0]  OpcodeD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pcf;
    logic [CW-1:0] r_drop;

    fetch_entry_t  w_q_head;
    fetch_entry_t  w_pend_head;
    fetch_entry_t  w_out;
    logic          w_q_empty;
    logic          w_q_full;
    logic [CW-1:0] w_q_count;
    logic          w_pend_empty;
    logic          w_pend_full;
    logic [CW-1:0] w_pend_count;
    logic [CW-1:0] w_outstanding;
    logic [CW:0]   w_inflight;
    logic          w_req_fire;
    logic          w_rsp_take;
    logic          w_rsp_drop;
    logic          w_q_push;
    logic          w_q_pop;
    logic          w_out_valid;
    logic          w_unused;

    // Dropped responses are still on the bus, so they count against the cap.
    assign w_outstanding = w_pend_count + r_drop;
    assign w_inflight    = {1'b0, w_q_count} + {1'b0, w_outstanding};

    assign ImemReqValid = rst_n & ~Redirect & (w_inflight < (CW+1)'(DEPTH));
    assign ImemReqAddr  = r_pcf;
    assign w_req_fire   = ImemReqValid & ImemReqReady;

    assign w_rsp_drop = ImemRspValid & ~Redirect & (r_drop != '0);
    assign w_rsp_take = ImemRspValid & ~Redirect & (r_drop == '0) & ~w_pend_empty;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = w_rsp_take & w_q_empty;
    assign w_out_valid = ~w_q_empty | w_bypass;
    assign w_out       = w_q_empty ? '{pc: w_pend_head.pc, instr: ImemRspData} : w_q_head;
    assign w_q_push    = w_rsp_take & ~(w_bypass & ~StallD);
`else
    assign w_out_valid = ~w_q_empty;
    assign w_out       = w_q_head;
    assign w_q_push    = w_rsp_take;
`endif

    assign w_q_pop = ~w_q_empty & ~StallD & ~Redirect;

    fetch_fifo #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (Redirect),
        .i_push  (w_q_push),
        .i_data  ('{pc: w_pend_head.pc, instr: ImemRspData}),
        .i_pop   (w_q_pop),
        .o_head  (w_q_head),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_count (w_q_count)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (Redirect),
        .i_push  (w_req_fire),
        .i_data  ('{pc: r_pcf, instr: 32'h0}),
        .i_pop   (w_rsp_take),
        .o_head  (w_pend_head),
        .o_empty (w_pend_empty),
        .o_full  (w_pend_full),
        .o_count (w_pend_count)
    );

    // On redirect every outstanding response becomes a drop, except one arriving now.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcf  <= RESET_PC;
            r_drop <= '0;
        end else if (Redirect) begin
            r_pcf  <= {RedirectPC[31:2], 2'b00};
            r_drop <= w_outstanding - CW'(ImemRspValid && (w_outstanding != '0));
        end else begin
            if (w_req_fire) begin
                r_pcf <= r_pcf + 32'd4;
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    assign InstrValidD = w_out_valid;
    assign InstrD      = w_out_valid ? w_out.instr : NOP_INSTR;
    assign PCD         = w_out_valid ? w_out.pc : 32'h0;
    assign OpcodeD     = InstrD[6:0];
    assign PCPlus4D    = PCD + 32'd4;

    // Pending entries never carry an instruction; low redirect bits are discarded.
    assign w_unused = ^{w_pend_head.instr, w_pend_full, RedirectPC[1:0]};

    assert property (@(posedge clk) disable iff (!rst_n) !(w_q_push && w_q_full && !w_q_pop));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: latency-programmable memory model plus a
// stream-level reference model checked every cycle.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ImemReqValid;
    logic [31:0] ImemReqAddr;
    logic        ImemReqReady;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        StallD;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrValidD;
    logic [31:0] InstrD;
    logic [6:0]  OpcodeD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ImemReqValid (ImemReqValid),
        .ImemReqAddr  (ImemReqAddr),
        .ImemReqReady (ImemReqReady),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .StallD       (StallD),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .InstrValidD  (InstrValidD),
        .InstrD       (InstrD),
        .OpcodeD      (OpcodeD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    bit          toggle_ready = 1'b0;

    // Reference model: next PC to issue, next PC decode must see, live requests
    // (issued on the current path, not yet consumed) and responses waiting for decode.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_exp_pc;
    int          m_live;
    int          m_arrived;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int       n_stale;
        mem_req_t r;
        bit       exp_valid;
        if (!rst_n) begin
            chk("req_valid_in_reset", 32'(ImemReqValid), 32'd0);
            mem_q.delete();
            m_fetch_pc = RESET_PC;
            m_exp_pc   = RESET_PC;
            m_live     = 0;
            m_arrived  = 0;
        end else begin
            n_stale = 0;
            foreach (mem_q[i]) if (mem_q[i].stale) n_stale++;
            chk("req_valid", 32'(ImemReqValid), 32'(!Redirect && (m_live + n_stale < DEPTH)));
            if (ImemReqValid) chk("req_addr", ImemReqAddr, m_fetch_pc);
            exp_valid = (m_arrived > 0);
            chk("instr_valid", 32'(InstrValidD), 32'(exp_valid));
            if (InstrValidD) begin
                chk("pcd", PCD, m_exp_pc);
                chk("instr", InstrD, imem_word(m_exp_pc));
                chk("opcode", 32'(OpcodeD), 32'(imem_word(m_exp_pc) & 32'h7F));
                chk("pcplus4", PCPlus4D, m_exp_pc + 32'd4);
            end else begin
                chk("nop_instr", InstrD, 32'h0000_0013);
                chk("nop_pcd", PCD, 32'h0);
                chk("nop_pcplus4", PCPlus4D, 32'h4);
            end
            if (Redirect) begin
                if (ImemRspValid && mem_q.size() > 0) r = mem_q.pop_front();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                m_live     = 0;
                m_arrived  = 0;
                m_fetch_pc = {RedirectPC[31:2], 2'b00};
                m_exp_pc   = {RedirectPC[31:2], 2'b00};
            end else begin
                if (ImemRspValid && mem_q.size() > 0) begin
                    r = mem_q.pop_front();
                    if (!r.stale) m_arrived++;
                end
                if (ImemReqValid && ImemReqReady) begin
                    mem_q.push_back('{m_fetch_pc, cyc + lat, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                    m_live++;
                end
                if (exp_valid && !StallD) begin
                    m_exp_pc = m_exp_pc + 32'd4;
                    m_live--;
                    m_arrived--;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        Redirect     = 1'b0;
        ImemReqReady = toggle_ready ? cyc[0] : 1'b1;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = imem_word(mem_q[0].addr);
        end else begin
            ImemRspValid = 1'b0;
            ImemRspData  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            next_cycle();
            @(negedge clk);
            seen = InstrValidD;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        bit seen;
        rst_n        = 1'b0;
        StallD       = 1'b0;
        Redirect     = 1'b0;
        RedirectPC   = 32'h0;
        ImemReqReady = 1'b1;
        ImemRspValid = 1'b0;
        ImemRspData  = 32'h0;

        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_valid", 32'(InstrValidD), 32'd0);
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_opcode", 32'(OpcodeD), 32'h13);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcplus4", PCPlus4D, 32'h4);

        // free run, 1-cycle memory
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_valid", 32'(ImemReqValid), 32'd1);
        chk("first_req_addr", ImemReqAddr, RESET_PC);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("first_valid_lat", 32'(InstrValidD), 32'd1);
        chk("first_pcd", PCD, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("second_instr", InstrD, 32'h78DD_E6D7);
        next_cycle();
        @(negedge clk);
        chk("bubble_valid", 32'(InstrValidD), 32'd0);
        repeat (10) next_cycle();

        // decode stalled for 5 cycles
        do_reset();
        StallD = 1'b1;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("stall_no_req", 32'(ImemReqValid), 32'd0);
        chk("stall_pcd", PCD, 32'h0);
        next_cycle();
        StallD = 1'b0;
        @(negedge clk);
        chk("release_pcd0", PCD, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("release_pcd4", PCD, 32'h4);
        repeat (8) next_cycle();

        // redirect with two requests in flight
        do_reset();
        lat = 3;
        next_cycle();
        next_cycle();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0102;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            next_cycle();
            @(negedge clk);
            seen = ImemReqValid;
        end
        chk("redir_req_seen", 32'(seen), 32'd1);
        chk("redir_req_addr", ImemReqAddr, 32'h0000_0100);
        wait_valid("redir_valid_seen");
        chk("redir_pcd", PCD, 32'h0000_0100);
        chk("redir_instr", InstrD, 32'h3779_B113);
        repeat (6) next_cycle();

        // redirect coinciding with an arriving response
        do_reset();
        lat  = 2;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            next_cycle();
            seen = ImemRspValid;
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0203;
        next_cycle();
        @(negedge clk);
        chk("redir_rsp_req_valid", 32'(ImemReqValid), 32'd1);
        chk("redir_rsp_req_addr", ImemReqAddr, 32'h0000_0200);
        wait_valid("redir_rsp_valid_seen");
        chk("redir_rsp_pcd", PCD, 32'h0000_0200);

        // back-to-back redirects
        lat = 1;
        repeat (4) next_cycle();
        next_cycle();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0300;
        next_cycle();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0404;
        wait_valid("b2b_valid_seen");
        chk("b2b_pcd", PCD, 32'h0000_0404);
        repeat (4) next_cycle();

        // ready toggling, 3-cycle memory, intermittent stalls
        toggle_ready = 1'b1;
        lat = 3;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            StallD = ((k % 7) == 3) || ((k % 7) == 4);
        end
        StallD       = 1'b0;
        toggle_ready = 1'b0;
        repeat (8) next_cycle();

        // reset with a full queue
        lat    = 1;
        StallD = 1'b1;
        repeat (5) next_cycle();
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n  = 1'b1;
        StallD = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(InstrValidD), 32'd0);
        chk("midrst_instr", InstrD, 32'h0000_0013);
        chk("midrst_req_addr", ImemReqAddr, RESET_PC);
        repeat (10) next_cycle();

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
